fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction-fetch stage directly upstream of the main decoder. Owns the PC,
//  issues word reads to instruction memory over a req/ack handshake, and holds
//  the fetched instruction for decode (op = Instr[6:0], funct3 = Instr[14:12]).
//  Decode consumes it over a valid/ready handshake. Branch/jal redirects arrive
//  on PCSrc/PCTarget.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset release
//  NOP_INSTR 32'h0000_0013  Instr value while no valid instruction is held (addi x0,x0,0)
// PORTS
//  clk          in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-low reset
//  PCSrc        in   1   redirect request, one-cycle pulse
//  PCTarget     in   32  redirect address, sampled when PCSrc=1
//  imem_req     out  1   read request to instruction memory
//  imem_addr    out  32  word address of the request, bits [1:0] always 0
//  imem_ack     in   1   read complete; imem_rdata valid this cycle
//  imem_rdata   in   32  instruction word
//  Instr        out  32  held instruction to the decoder
//  PC           out  32  address of Instr
//  PCPlus4      out  32  PC + 4, combinational from the PC register, mod 2^32
//  instr_valid  out  1   Instr/PC are valid for decode
//  instr_ready  in   1   decode accepts Instr this cycle
// BEHAVIOUR
//  Clocking and reset: one clock; reset is asynchronous and active-low.
//  While reset=0, all outputs are forced immediately:
//    PC=RESET_PC, fetch_pc=RESET_PC, Instr=NOP_INSTR, instr_valid=0, imem_req=0.
//    State goes to FETCH.
//  An outstanding memory read is abandoned when reset asserts.
//  imem_req rises on the first clk edge after reset is released.
//  States:
//  - FETCH: imem_req=1 and imem_addr=fetch_pc. Both stay stable until imem_ack.
//    On imem_ack (no redirect): Instr<=imem_rdata, PC<=fetch_pc,
//    fetch_pc<=fetch_pc+4, instr_valid<=1, go to HOLD.
//  - HOLD: imem_req=0. Instr and PC stay stable while instr_valid=1 && instr_ready=0.
//    On instr_ready: instr_valid<=0, Instr<=NOP_INSTR, go to FETCH.
//  - DRAIN: a redirect was taken while a read was outstanding.
//    imem_req stays 1 with the old imem_addr until imem_ack. The returned data is discarded.
//    Then go to FETCH at fetch_pc (which already holds the target).
//  Latency: imem_ack in cycle N gives instr_valid=1 in cycle N+1.
//    Zero-wait memory (ack in the request cycle) sustains 1 instruction per 2 cycles.
//  Redirect (PCSrc=1) has the highest priority in every state.
//    fetch_pc<={PCTarget[31:2],2'b00}; target bits [1:0] are ignored.
//  Redirect handling by state:
//  - FETCH, no ack: go to DRAIN.
//  - FETCH, same-cycle ack: discard imem_rdata and stay in FETCH.
//    The next cycle requests the target.
//  - HOLD: instr_valid<=0 and Instr<=NOP_INSTR whether or not instr_ready=1.
//    The held instruction counts as consumed. Go to FETCH.
//  - DRAIN: the newest PCTarget overwrites fetch_pc (latest redirect wins).
//  Wrap-around: fetch_pc 32'hFFFF_FFFC + 4 = 32'h0000_0000. PCPlus4 wraps the same way.
//  A discarded (drained or redirected) read never raises instr_valid.
//  imem_ack is ignored outside FETCH/DRAIN.
// TESTING
//  1. Reset, then release with ack in the same cycle as req and instr_ready tied to 1.
//     Addresses 0,4,8,... in order. instr_valid pulses every 2nd cycle.
//     Instr matches the memory image and PC matches each address.
//  2. Backpressure: hold instr_ready=0 for 5 cycles in HOLD.
//     Instr/PC stay stable, imem_req=0, and there are no duplicate or skipped addresses after release.
//  3. Redirect with PCSrc=1, PCTarget=32'h0000_0103 while in FETCH with ack delayed 3 cycles.
//     The old read completes with data dropped and instr_valid stays 0.
//     The next imem_addr is 32'h0000_0100.
//  4. Redirect while in HOLD together with instr_ready=1, then a second redirect during DRAIN.
//     The held instruction is dropped. Only the last target is fetched.
//  5. Wrap-around: redirect to 32'hFFFF_FFFC. PCPlus4=0 and the next fetch is at 0.
//  6. Assert reset mid-FETCH with an ack pending.
//     Outputs go to reset values at once with no clock edge needed.
//     The first post-reset request is at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory over req/ack,
// and holds one fetched instruction for the decoder over a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] PCTarget,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instr,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        instr_valid,
    input  logic        instr_ready
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] target_s;

    assign target_s    = PCTarget & 32'hFFFF_FFFC;
    assign imem_req    = req_q;
    assign imem_addr   = addr_q;
    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_q + 32'd4;
    assign instr_valid = valid_q;

    // Next-state logic; addr_q only moves when a new request starts, so a
    // drained read keeps its original address while fetch_pc already holds the target.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        case (state_q)
            S_FETCH: begin
                if (PCSrc) begin
                    fetch_pc_d = target_s;
                    req_d      = 1'b1;
                    if (req_q && !imem_ack) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_FETCH;
                        addr_d  = target_s;
                    end
                end else if (req_q && imem_ack) begin
                    instr_d    = imem_rdata;
                    pc_d       = fetch_pc_q;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    valid_d    = 1'b1;
                    req_d      = 1'b0;
                    state_d    = S_HOLD;
                end else begin
                    req_d  = 1'b1;
                    addr_d = fetch_pc_q;
                end
            end
            S_HOLD: begin
                if (PCSrc) begin
                    fetch_pc_d = target_s;
                    addr_d     = target_s;
                    valid_d    = 1'b0;
                    instr_d    = NOP_INSTR;
                    req_d      = 1'b1;
                    state_d    = S_FETCH;
                end else if (instr_ready) begin
                    addr_d  = fetch_pc_q;
                    valid_d = 1'b0;
                    instr_d = NOP_INSTR;
                    req_d   = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    req_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (PCSrc) begin
                    fetch_pc_d = target_s;
                end else begin
                    fetch_pc_d = fetch_pc_q;
                end
                req_d = 1'b1;
                if (imem_ack) begin
                    addr_d  = fetch_pc_d;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d    = S_FETCH;
                req_d      = 1'b0;
                addr_d     = RESET_PC;
                fetch_pc_d = RESET_PC;
                valid_d    = 1'b0;
                instr_d    = NOP_INSTR;
            end
        endcase
    end

    // State and output registers; reset abandons any outstanding read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_FETCH;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            fetch_pc_q <= RESET_PC;
            pc_q       <= RESET_PC;
            instr_q    <= NOP_INSTR;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

endmodule
